fir_mac_sequencer: RTL and testbench
====================================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 10, input sample width (unsigned).
REQ-002 SHALL have parameter OUTPUT_DATA_WIDTH, default 2*INPUT_DATA_WIDTH+2, result width.
REQ-003 SHALL have port clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_valid  input  1  input sample valid.
REQ-006 SHALL have port s_ready  output  1  block can accept a sample.
REQ-007 SHALL have port s_data  input  INPUT_DATA_WIDTH  input sample.
REQ-008 SHALL have port m_valid  output  1  result valid.
REQ-009 SHALL have port m_ready  input  1  downstream accepts result.
REQ-010 SHALL have port m_data  output  OUTPUT_DATA_WIDTH  filtered result.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 SHALL implement the 9-tap lowpass FIR y[n] = sum over k=0..8 of c[k]*x[n-k], c = {7,17,32,46,52,46,32,17,7}, using one shared multiplier time-multiplexed across taps.
REQ-013 SHALL hold the last 9 samples in a circular buffer with write pointer wp wrapping 8 -> 0.
REQ-014 SHALL use FSM states IDLE, ACC, OUT; transitions IDLE->ACC on accept, ACC->OUT after tap 8, OUT->IDLE on m_valid&&m_ready.
REQ-015 s_ready SHALL be 1 only in IDLE; accept = s_valid&&s_ready; s_valid ignored in ACC and OUT.
REQ-016 On accept, SHALL write s_data at wp, clear accumulator, set tap index k=0.
REQ-017 In ACC, each cycle SHALL add c[k]*buf[(wp_new - k) mod 9] to the accumulator, k incrementing 0..8; exactly 9 ACC cycles.
REQ-018 m_valid SHALL rise exactly 9 clock edges after the accept edge and hold m_data stable until m_ready is sampled high.
REQ-019 m_ready high in the same cycle m_valid rises SHALL complete transfer that edge; s_ready returns 1 the following cycle (minimum 11-cycle sample period).
REQ-020 Accumulator SHALL be OUTPUT_DATA_WIDTH bits unsigned; max result 1023*256 = 261888 fits without overflow at defaults.
REQ-021 m_data SHALL be bit-exact with the fully parallel FIR on the same sample sequence.

Reset
REQ-022 While rst_in is high, SHALL set state IDLE, buffer all zero, wp=0, k=0, accumulator 0, m_valid=0, m_data=0, busy=0, s_ready=0.
REQ-023 s_ready SHALL be 1 in the first cycle after rst_in deasserts.
REQ-024 Reset asserted during ACC or OUT SHALL discard the in-flight result; no m_valid pulse SHALL follow.

Configuration
REQ-025 Macro FIR_MAC_ROUND_EN SHALL select output scaling.
REQ-026 With FIR_MAC_ROUND_EN defined, m_data SHALL be (acc+128)>>8 zero-extended (unity DC gain, round-half-up).
REQ-027 Without FIR_MAC_ROUND_EN, m_data SHALL be the raw accumulator.

Structure
REQ-028 Package fir_pkg SHALL hold FIR_ORDER=8, FIR_TAPS=9, the coefficient constant array (8-bit), and the state enum typedef.
REQ-029 Multiply-accumulate SHALL be one sub-module fir_mac (clear, enable, coef, sample -> acc); FSM and buffer stay in fir_mac_sequencer.

Verification
REQ-030 Impulse: after reset, send 1 then eight 0s, m_ready=1 -> m_data sequence 7,17,32,46,52,46,32,17,7.
REQ-031 Step: send 1023 nine times -> ninth result 261888; 10th sample 1023 -> 261888.
REQ-032 Backpressure: hold m_ready=0 5 cycles after m_valid -> m_valid and m_data stable, s_ready=0, s_valid pulses ignored, no buffer write.
REQ-033 Reset mid-ACC (4th ACC cycle) -> no m_valid; next impulse 1 gives 7 (buffer cleared).
REQ-034 Timing: accept at edge E0 -> m_valid first high after E9; m_ready=1 -> s_ready high after E10.
REQ-035 FIR_MAC_ROUND_EN defined: impulse 128 -> first result (896+128)>>8 = 4; step 1023 settled -> 1023.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, coefficient table and FSM state type for the FIR MAC sequencer.
// The coefficient set is a symmetric 9-tap lowpass whose taps sum to 256.
package fir_pkg;

   localparam int FIR_ORDER  = 8;
   localparam int FIR_TAPS   = FIR_ORDER + 1;
   localparam int COEF_WIDTH = 8;

   localparam logic [COEF_WIDTH-1:0] FIR_COEF [FIR_TAPS] = '{
      8'd7, 8'd17, 8'd32, 8'd46, 8'd52, 8'd46, 8'd32, 8'd17, 8'd7
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } fir_state_t;

   // Circular-buffer slot of x[n-k], given the write pointer already advanced
   // past the newest sample: (wp - 1 - k) mod 9, kept non-negative by adding 9.
   function automatic logic [3:0] tap_index(input logic [3:0] wp, input logic [3:0] k);
      logic [4:0] s;
      s = 5'(wp) + 5'd8 - 5'(k);
      return (s >= 5'd9) ? 4'(s - 5'd9) : 4'(s);
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Single shared multiply-accumulate unit: acc <= acc + coef*sample when enabled.
// clear has priority over enable so a new sample starts from zero.
module fir_mac
   import fir_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 10,
   parameter int ACC_WIDTH    = 22
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [COEF_WIDTH-1:0] coef,
   input  logic [SAMPLE_WIDTH-1:0] sample,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic [ACC_WIDTH-1:0] prod;

   assign prod = ACC_WIDTH'(coef) * ACC_WIDTH'(sample);

   // Accumulator register
   always_ff @(posedge clk_in) begin
      if (rst_in || clear)
         acc <= '0;
      else if (enable)
         acc <= acc + prod;
   end

endmodule

// File: rtl/fir_mac_sequencer.sv
// 9-tap lowpass FIR with one time-multiplexed multiplier.
// A sample is accepted in IDLE, nine ACC cycles walk the taps, and the result
// is held in OUT until the downstream handshake completes.
// Build option: define FIR_MAC_ROUND_EN to output (acc+128)>>8 (unity DC gain,
// round-half-up) instead of the raw accumulator.
module fir_mac_sequencer
   import fir_pkg::*;
#(
   parameter int INPUT_DATA_WIDTH  = 10,
   parameter int OUTPUT_DATA_WIDTH = 2*INPUT_DATA_WIDTH+2
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [INPUT_DATA_WIDTH-1:0]  s_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [OUTPUT_DATA_WIDTH-1:0] m_data,
   output logic                         busy
);

   fir_state_t state, state_nxt;

   logic [INPUT_DATA_WIDTH-1:0]  smp_buf [FIR_TAPS];
   logic [3:0]                   wp;
   logic [3:0]                   k;
   logic [3:0]                   rd_idx;
   logic                         accept;
   logic                         mac_en;
   logic [OUTPUT_DATA_WIDTH-1:0] acc;
   logic [OUTPUT_DATA_WIDTH-1:0] result;

   // State register
   always_ff @(posedge clk_in) begin
      if (rst_in)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and handshake outputs; everything forced quiet while in reset
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      mac_en    = 1'b0;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            accept  = s_valid;
            if (s_valid)
               state_nxt = ACC;
         end
         ACC: begin
            busy   = 1'b1;
            mac_en = 1'b1;
            if (k == 4'(FIR_ORDER))
               state_nxt = OUT;
         end
         OUT: begin
            busy    = 1'b1;
            m_valid = 1'b1;
            if (m_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (rst_in) begin
         s_ready = 1'b0;
         m_valid = 1'b0;
         busy    = 1'b0;
         accept  = 1'b0;
         mac_en  = 1'b0;
      end
   end

   // Sample buffer, write pointer and tap index
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < FIR_TAPS; i++)
            smp_buf[i] <= '0;
         wp <= '0;
         k  <= '0;
      end else if (accept) begin
         smp_buf[wp] <= s_data;
         wp          <= (wp == 4'(FIR_ORDER)) ? 4'd0 : wp + 4'd1;
         k           <= '0;
      end else if (mac_en && (k != 4'(FIR_ORDER))) begin
         k <= k + 4'd1;
      end
   end

   assign rd_idx = tap_index(wp, k);

   fir_mac #(
      .SAMPLE_WIDTH (INPUT_DATA_WIDTH),
      .ACC_WIDTH    (OUTPUT_DATA_WIDTH)
   ) u_mac (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clear  (accept),
      .enable (mac_en),
      .coef   (FIR_COEF[k]),
      .sample (smp_buf[rd_idx]),
      .acc    (acc)
   );

`ifdef FIR_MAC_ROUND_EN
   logic [OUTPUT_DATA_WIDTH:0] acc_rnd;

   // One spare bit so the rounding constant cannot wrap
   assign acc_rnd = {1'b0, acc} + (OUTPUT_DATA_WIDTH+1)'(128);
   assign result  = OUTPUT_DATA_WIDTH'(acc_rnd >> 8);
`else
   assign result  = acc;
`endif

   // The accumulator is frozen in OUT, so the result is stable while waiting
   assign m_data = rst_in ? '0 : result;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed vectors, a sample-history
// reference model checked every cycle, and literal expectations per result.
module tb_fir_mac_sequencer;

   localparam int IW = 10;
   localparam int OW = 2*IW+2;
`ifdef FIR_MAC_ROUND_EN
   localparam bit RND = 1'b1;
   localparam int IMP = 128;
`else
   localparam bit RND = 1'b0;
   localparam int IMP = 1;
`endif
   localparam int N_RESULTS = 21;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          s_valid;
   logic          s_ready;
   logic [IW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [OW-1:0] m_data;
   logic          busy;

   fir_mac_sequencer #(.INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW)) dut (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .busy    (busy)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;
   int lit_exp [int];
   bit tmo  = 1'b0;
   bit done = 1'b0;

   // Reference model: phase 0 idle, 1 computing, 2 result offered
   int  ph = 0;
   int  cnt = 0;
   int  hist [9];
   longint exp_y = 0;
   int  nres = 0;
   bit  final_done = 1'b0;
   int  coef [9] = '{7, 17, 32, 46, 52, 46, 32, 17, 7};

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial for (int i = 0; i < 9; i++) hist[i] = 0;

   // Compare current outputs with the model, then advance the model using the
   // inputs that the next rising edge will sample
   always @(negedge clk_in) begin
      chk("s_ready", s_ready, (!rst_in && ph == 0) ? 1 : 0);
      chk("m_valid", m_valid, (!rst_in && ph == 2) ? 1 : 0);
      chk("busy",    busy,    (!rst_in && ph != 0) ? 1 : 0);
      if (rst_in)
         chk("m_data_rst", m_data, 0);
      else if (ph == 2)
         chk("m_data", m_data, exp_y);

      if (!rst_in && ph == 2 && m_ready) begin
         if (lit_exp.exists(nres))
            chk($sformatf("result%0d", nres), m_data, lit_exp[nres]);
         nres++;
      end

      if (rst_in) begin
         ph = 0;
         for (int i = 0; i < 9; i++) hist[i] = 0;
      end else begin
         case (ph)
            0: if (s_valid) begin
               for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
               hist[0] = int'(s_data);
               exp_y = 0;
               for (int i = 0; i < 9; i++) exp_y += longint'(coef[i]) * hist[i];
               if (RND) exp_y = (exp_y + 128) >> 8;
               ph  = 1;
               cnt = 0;
            end
            1: begin
               cnt++;
               if (cnt == 9) ph = 2;
            end
            default: if (m_ready) ph = 0;
         endcase
      end

      if (done && !final_done) begin
         chk("timeout", tmo, 0);
         chk("result_count", nres, N_RESULTS);
         final_done = 1'b1;
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < 60; i++) begin
         if (s_ready) break;
         @(posedge clk_in); #1;
      end
      if (!s_ready) tmo = 1'b1;
   endtask

   task automatic send(input int d);
      wait_ready();
      s_valid = 1'b1;
      s_data  = IW'(d);
      @(posedge clk_in); #1;
      s_valid = 1'b0;
   endtask

   initial begin
      rst_in  = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b1;

      // Hand-computed expectations per delivered result index
      if (RND) begin
         int r [9] = '{4, 9, 16, 23, 26, 23, 16, 9, 4};
         for (int i = 0; i < 9; i++) lit_exp[i] = r[i];
         lit_exp[9]  = 28;     // (7161+128)>>8
         lit_exp[17] = 1023;
         lit_exp[18] = 1023;
         lit_exp[19] = 1009;   // (258227+128)>>8
         lit_exp[20] = 4;
      end else begin
         for (int i = 0; i < 9; i++) lit_exp[i] = coef[i];
         lit_exp[9]  = 7161;   // 7*1023, impulse tail shifted out
         lit_exp[17] = 261888;
         lit_exp[18] = 261888;
         lit_exp[19] = 258227; // 7*500 + 249*1023
         lit_exp[20] = 7;
      end

      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b0;

      // Impulse response
      for (int i = 0; i < 9; i++) send(i == 0 ? IMP : 0);

      // Step, plus one extra to cross the pointer wrap again
      for (int i = 0; i < 10; i++) send(1023);

      // Backpressure with ignored s_valid pulses while the result is held
      wait_ready();
      m_ready = 1'b0;
      send(500);
      for (int i = 0; i < 40; i++) begin
         if (m_valid) break;
         @(posedge clk_in); #1;
      end
      if (!m_valid) tmo = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_valid = (i % 2 == 0);
         s_data  = 10'd77;
         @(posedge clk_in); #1;
      end
      s_valid = 1'b0;
      m_ready = 1'b1;

      // Reset during the fourth ACC cycle discards the result and the buffer
      send(300);
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b1;
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b0;
      send(IMP);
      wait_ready();

      repeat (3) @(posedge clk_in);
      done = 1'b1;
      repeat (3) @(negedge clk_in);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
